factorial_requester: RTL and testbench
======================================

// Module: factorial_requester
// PURPOSE
//  Initiator side of the factorial DUT handshake (in_data/in_valid -> out_data/out_valid/out_busy).
//  - Accepts arguments from an upstream valid/ready stream and issues one request at a time.
//  - Waits for the result, with a timeout, and checks it against a factorial table.
//  - Returns {arg, result, flags} on a downstream valid/ready stream and keeps saturating statistics.
//  - Sits between a test/traffic source and the factorial core.
// PARAMETERS
//  IN_DATA_WD   4    argument width; legal range 1..4 (elaboration error otherwise)
//  OUT_DATA_WD  46   result width; must be >= 41 (15! = 1307674368000)
//  TIMEOUT_CYC  64   max cycles in WAIT before a timeout; >= 2
//  CNT_WD       16   statistics counter width
// PORTS
//  clk             in   1            clock, rising edge
//  resetn          in   1            synchronous reset, active-low
//  req_data        in   IN_DATA_WD   argument from upstream
//  req_valid       in   1            upstream valid
//  req_ready       out  1            block can accept an argument
//  fact_in_data    out  IN_DATA_WD   argument to factorial core
//  fact_in_valid   out  1            one-cycle request strobe to core
//  fact_out_data   in   OUT_DATA_WD  core result
//  fact_out_valid  in   1            core result strobe (one cycle)
//  fact_out_busy   in   1            core busy
//  rsp_arg         out  IN_DATA_WD   argument of the returned result
//  rsp_data        out  OUT_DATA_WD  captured result (0 on timeout)
//  rsp_mismatch    out  1            rsp_data != table[rsp_arg] and no timeout
//  rsp_timeout     out  1            no result within TIMEOUT_CYC cycles
//  rsp_valid       out  1            response valid
//  rsp_ready       in   1            downstream ready
//  done_cnt        out  CNT_WD       responses delivered
//  mismatch_cnt    out  CNT_WD       mismatches delivered
//  timeout_cnt     out  CNT_WD       timeouts delivered
//  spurious_cnt    out  CNT_WD       fact_out_valid pulses outside WAIT
// BEHAVIOUR
//  Reset: resetn sampled low -> all outputs and registers 0 at the next edge; state IDLE.
//  States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - req_ready = !fact_out_busy.
//   - On req_valid && req_ready: latch req_data; go to ISSUE.
//  ISSUE
//   - fact_in_valid=1 and fact_in_data=arg for exactly one cycle. req_ready=0.
//   - Clear the timer; go to WAIT.
//  WAIT
//   - Timer increments each cycle.
//   - fact_out_valid: capture fact_out_data; go to RESP.
//   - Otherwise, when timer == TIMEOUT_CYC-1: set timeout, data=0; go to RESP.
//   - fact_out_valid in the same cycle as the timeout boundary: the result wins, no timeout.
//  RESP
//   - rsp_valid=1. rsp_arg, rsp_data and flags are registered and held stable until rsp_ready.
//   - On rsp_valid && rsp_ready: bump done_cnt, plus mismatch_cnt or timeout_cnt; go to IDLE.
//   - rsp_ready may be held high continuously; back-to-back requests are still allowed.
//  Latency (timing diagram)
//   - Accept at cycle t -> fact_in_valid at t+1.
//   - fact_out_valid at cycle u -> rsp_valid at u+1.
//   - Minimum accept-to-accept time is 4 cycles plus core latency.
//  Mismatch: computed in WAIT from the ROM entry for the latched arg; registered with the data.
//  Spurious results: fact_out_valid in IDLE, ISSUE or RESP is ignored for data and increments spurious_cnt.
//  Counters: saturate at all-ones and never wrap.
//  fact_out_busy
//   - Only gates acceptance in IDLE.
//   - Ignored in WAIT; a busy core with no result ends in a timeout.
//  Reset mid-operation (synchronous): state returns to IDLE, fact_in_valid and rsp_valid drop,
//   the in-flight result is discarded, and counters clear.
//  Outputs are registered; req_ready is combinational from state and fact_out_busy.
// STRUCTURE
//  factorial_pkg
//   - Width defaults.
//   - State enum req_state_e {IDLE, ISSUE, WAIT, RESP}.
//   - Constant array FACT_TABLE[16] of 64-bit factorials 0!..15!.
//  Sub-module sat_counter #(CNT_WD): inc, count; instanced 4x for the statistics.
//  Top: FSM, arg/result registers, timer, compare against FACT_TABLE[arg][OUT_DATA_WD-1:0].
// TESTING
//  1 arg 5; model core answers 120 after 6 cycles
//    -> fact_in_valid one cycle after accept; rsp_data=120, mismatch=0, done_cnt=1.
//  2 args 0 then 15, back-to-back, rsp_ready held 1
//    -> rsp_data 1 then 1307674368000; flags 0; done_cnt=2.
//  3 arg 4; model answers 25
//    -> rsp_mismatch=1, rsp_data=25, mismatch_cnt=1.
//  4 arg 7; core silent for 64 cycles
//    -> rsp_timeout=1, rsp_data=0, timeout_cnt=1.
//  4b same as 4, but the result arrives on cycle 63 of WAIT
//    -> no timeout.
//  5 fact_out_busy=1 in IDLE with req_valid=1
//    -> req_ready=0, no fact_in_valid. Unsolicited fact_out_valid -> spurious_cnt=1.
//  6 rsp_ready low for 10 cycles
//    -> response held stable.
//  6b resetn low for 1 cycle during WAIT
//    -> next edge: IDLE, all counters 0; a late core result counts as spurious.

Source files
------------

// File: rtl/factorial_pkg.sv
// Shared definitions for the factorial requester.
//   - Default widths for the requester parameters.
//   - Requester FSM state encoding.
//   - Reference table of 0!..15! used to check core results.
package factorial_pkg;

    localparam int DEF_IN_DATA_WD  = 4;
    localparam int DEF_OUT_DATA_WD = 46;
    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int DEF_CNT_WD      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } req_state_e;

    localparam logic [63:0] FACT_TABLE [16] = '{
        64'd1,
        64'd1,
        64'd2,
        64'd6,
        64'd24,
        64'd120,
        64'd720,
        64'd5040,
        64'd40320,
        64'd362880,
        64'd3628800,
        64'd39916800,
        64'd479001600,
        64'd6227020800,
        64'd87178291200,
        64'd1307674368000
    };

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
// Ports:
//   clk     in   clock, rising edge
//   resetn  in   synchronous reset, active-low
//   inc     in   count enable for this cycle
//   count   out  current count
module sat_counter #(
    parameter int CNT_WD = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc,
    output logic [CNT_WD-1:0] count
);

    logic [CNT_WD-1:0] count_q;
    logic [CNT_WD-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WD'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/factorial_requester.sv
// Initiator for the factorial core handshake. Takes one argument at a time
// from an upstream valid/ready stream, strobes it into the core, waits for
// the result (bounded by a timeout), checks it against the reference table
// and returns {arg, result, flags} downstream, with saturating statistics.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for an argument unless the core reports busy
// ISSUE | one-cycle request strobe to the core, timer armed
// WAIT  | waiting for the core result or the timeout
// RESP  | response held on rsp_* until downstream takes it
//
// Ports:
//   clk, resetn                          clock / synchronous active-low reset
//   req_data, req_valid, req_ready       upstream argument stream
//   fact_in_data, fact_in_valid          request to the core
//   fact_out_data, fact_out_valid        result from the core
//   fact_out_busy                        core busy (gates acceptance in IDLE)
//   rsp_arg, rsp_data, rsp_mismatch,
//   rsp_timeout, rsp_valid, rsp_ready    downstream response stream
//   done_cnt, mismatch_cnt,
//   timeout_cnt, spurious_cnt            saturating statistics
module factorial_requester
    import factorial_pkg::*;
#(
    parameter int IN_DATA_WD  = DEF_IN_DATA_WD,
    parameter int OUT_DATA_WD = DEF_OUT_DATA_WD,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_WD      = DEF_CNT_WD
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [IN_DATA_WD-1:0]  req_data,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [IN_DATA_WD-1:0]  fact_in_data,
    output logic                   fact_in_valid,
    input  logic [OUT_DATA_WD-1:0] fact_out_data,
    input  logic                   fact_out_valid,
    input  logic                   fact_out_busy,
    output logic [IN_DATA_WD-1:0]  rsp_arg,
    output logic [OUT_DATA_WD-1:0] rsp_data,
    output logic                   rsp_mismatch,
    output logic                   rsp_timeout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [CNT_WD-1:0]      done_cnt,
    output logic [CNT_WD-1:0]      mismatch_cnt,
    output logic [CNT_WD-1:0]      timeout_cnt,
    output logic [CNT_WD-1:0]      spurious_cnt
);

    if ((IN_DATA_WD < 1) || (IN_DATA_WD > 4)) begin : g_bad_in_wd
        $error("factorial_requester: IN_DATA_WD must be 1..4");
    end
    if ((OUT_DATA_WD < 41) || (OUT_DATA_WD > 64)) begin : g_bad_out_wd
        $error("factorial_requester: OUT_DATA_WD must be 41..64");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("factorial_requester: TIMEOUT_CYC must be >= 2");
    end

    // Down-counter: loaded in ISSUE, terminal count 0 is the last WAIT cycle,
    // which is the TIMEOUT_CYC-th cycle spent in WAIT.
    localparam int TMR_WD = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_WD-1:0] TMR_LOAD = TMR_WD'(TIMEOUT_CYC - 1);

    req_state_e             state_q,    state_d;
    logic [IN_DATA_WD-1:0]  arg_q,      arg_d;
    logic [OUT_DATA_WD-1:0] data_q,     data_d;
    logic                   mismatch_q, mismatch_d;
    logic                   timeout_q,  timeout_d;
    logic [TMR_WD-1:0]      timer_q,    timer_d;

    logic                   accept;
    logic                   rsp_fire;
    logic                   timer_tc;
    logic [3:0]             arg_idx;
    logic [OUT_DATA_WD-1:0] fact_exp;

    assign accept   = (state_q == IDLE) && req_valid && !fact_out_busy;
    assign rsp_fire = (state_q == RESP) && rsp_ready;
    assign timer_tc = (timer_q == '0);
    assign arg_idx  = 4'(arg_q);
    assign fact_exp = OUT_DATA_WD'(FACT_TABLE[arg_idx]);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            arg_q      <= '0;
            data_q     <= '0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            arg_q      <= arg_d;
            data_q     <= data_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (accept) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (fact_out_valid || timer_tc) state_d = RESP;
            RESP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arg_d      = arg_q;
        data_d     = data_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        timer_d    = timer_q;
        case (state_q)
            IDLE: begin
                if (accept) arg_d = req_data;
            end
            ISSUE: begin
                timer_d    = TMR_LOAD;
                data_d     = '0;
                mismatch_d = 1'b0;
                timeout_d  = 1'b0;
            end
            WAIT: begin
                if (!timer_tc) timer_d = timer_q - TMR_WD'(1);
                // A result on the terminal cycle still beats the timeout.
                if (fact_out_valid) begin
                    data_d     = fact_out_data;
                    mismatch_d = (fact_out_data != fact_exp);
                end else if (timer_tc) begin
                    data_d    = '0;
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready     = (state_q == IDLE) && !fact_out_busy;
        fact_in_valid = (state_q == ISSUE);
        fact_in_data  = arg_q;
        rsp_valid     = (state_q == RESP);
        rsp_arg       = arg_q;
        rsp_data      = data_q;
        rsp_mismatch  = mismatch_q;
        rsp_timeout   = timeout_q;
    end

    sat_counter #(.CNT_WD(CNT_WD)) u_done_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (rsp_fire),
        .count  (done_cnt)
    );

    sat_counter #(.CNT_WD(CNT_WD)) u_mismatch_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (rsp_fire && mismatch_q),
        .count  (mismatch_cnt)
    );

    sat_counter #(.CNT_WD(CNT_WD)) u_timeout_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (rsp_fire && timeout_q),
        .count  (timeout_cnt)
    );

    // Results outside WAIT are dropped for data but still counted.
    sat_counter #(.CNT_WD(CNT_WD)) u_spurious_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (fact_out_valid && (state_q != WAIT)),
        .count  (spurious_cnt)
    );

endmodule

// File: tb/tb_factorial_requester.sv
module tb_factorial_requester;

    localparam int IW   = 4;
    localparam int OW   = 46;
    localparam int CW   = 3;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk;
    logic          resetn;
    logic [IW-1:0] req_data;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] fact_in_data;
    logic          fact_in_valid;
    logic [OW-1:0] fact_out_data;
    logic          fact_out_valid;
    logic          fact_out_busy;
    logic [IW-1:0] rsp_arg;
    logic [OW-1:0] rsp_data;
    logic          rsp_mismatch;
    logic          rsp_timeout;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [CW-1:0] done_cnt;
    logic [CW-1:0] mismatch_cnt;
    logic [CW-1:0] timeout_cnt;
    logic [CW-1:0] spurious_cnt;

    factorial_requester #(
        .IN_DATA_WD  (IW),
        .OUT_DATA_WD (OW),
        .TIMEOUT_CYC (64),
        .CNT_WD      (CW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .fact_in_data   (fact_in_data),
        .fact_in_valid  (fact_in_valid),
        .fact_out_data  (fact_out_data),
        .fact_out_valid (fact_out_valid),
        .fact_out_busy  (fact_out_busy),
        .rsp_arg        (rsp_arg),
        .rsp_data       (rsp_data),
        .rsp_mismatch   (rsp_mismatch),
        .rsp_timeout    (rsp_timeout),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .done_cnt       (done_cnt),
        .mismatch_cnt   (mismatch_cnt),
        .timeout_cnt    (timeout_cnt),
        .spurious_cnt   (spurious_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] arg;
        logic [OW-1:0] val;
        int            lat;
        bit            silent;
        logic [OW-1:0] exp_data;
        bit            exp_mis;
        bit            exp_to;
    } vec_t;

    typedef struct {
        logic [IW-1:0] arg;
        logic [OW-1:0] data;
        bit            mis;
        bit            to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    int n_cmp = 0;
    int n_err = 0;

    logic [CW-1:0] exp_done = '0;
    logic [CW-1:0] exp_mis  = '0;
    logic [CW-1:0] exp_to   = '0;
    logic [CW-1:0] exp_spur = '0;

    // Model core configuration; captured when the request strobe is seen.
    logic [OW-1:0] core_val    = '0;
    int            core_lat    = 1;
    bit            core_silent = 1'b0;
    bit            core_pulsed = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? CMAX : v + CW'(1);
    endfunction

    // Model factorial core: answers core_val core_lat cycles after the strobe.
    initial begin
        logic [OW-1:0] val;
        int            lat;
        fact_out_valid = 1'b0;
        fact_out_data  = '0;
        forever begin
            @(negedge clk);
            if (core_pulsed) begin
                fact_out_valid = 1'b0;
                core_pulsed    = 1'b0;
            end
            if (fact_in_valid && !core_silent) begin
                val = core_val;
                lat = core_lat;
                repeat (lat) @(negedge clk);
                fact_out_data  = val;
                fact_out_valid = 1'b1;
                core_pulsed    = 1'b1;
            end
        end
    end

    // Response monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_arg", 64'(rsp_arg), 64'(e.arg));
                    chk("rsp_data", 64'(rsp_data), 64'(e.data));
                    chk("rsp_mismatch", 64'(rsp_mismatch), 64'(e.mis));
                    chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    exp_done = sat_inc(exp_done);
                    if (e.mis) exp_mis = sat_inc(exp_mis);
                    if (e.to)  exp_to  = sat_inc(exp_to);
                end
            end
        end
    end

    task automatic send(input logic [IW-1:0] a, input logic [OW-1:0] d, input bit m, input bit t);
        int n = 0;
        req_data  = a;
        req_valid = 1'b1;
        #1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_ready", 64'(req_ready), 64'd1);
        sb.push_back('{a, d, m, t});
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        chk("issue_valid", 64'(fact_in_valid), 64'd1);
        chk("issue_data", 64'(fact_in_data), 64'(a));
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #3;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
        chk({tag, "_mismatch_cnt"}, 64'(mismatch_cnt), 64'(exp_mis));
        chk({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'(exp_to));
        chk({tag, "_spurious_cnt"}, 64'(spurious_cnt), 64'(exp_spur));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{4'd5,  46'd120,           6,  1'b0, 46'd120,           1'b0, 1'b0};
        vecs[1] = '{4'd0,  46'd1,             2,  1'b0, 46'd1,             1'b0, 1'b0};
        vecs[2] = '{4'd15, 46'd1307674368000, 3,  1'b0, 46'd1307674368000, 1'b0, 1'b0};
        vecs[3] = '{4'd4,  46'd25,            4,  1'b0, 46'd25,            1'b1, 1'b0};
        vecs[4] = '{4'd7,  46'd5040,          1,  1'b1, 46'd0,             1'b0, 1'b1};
        vecs[5] = '{4'd7,  46'd5040,          64, 1'b0, 46'd5040,          1'b0, 1'b0};
        vecs[6] = '{4'd3,  46'd6,             1,  1'b0, 46'd6,             1'b0, 1'b0};
        vecs[7] = '{4'd9,  46'd362880,        63, 1'b0, 46'd362880,        1'b0, 1'b0};
        vecs[8] = '{4'd12, 46'd479001601,     10, 1'b0, 46'd479001601,     1'b1, 1'b0};

        resetn        = 1'b0;
        req_data      = '0;
        req_valid     = 1'b0;
        fact_out_busy = 1'b0;
        rsp_ready     = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_fact_in_valid", 64'(fact_in_valid), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk_counters("reset");
        resetn = 1'b1;
        @(negedge clk);
        #1;

        // Table-driven single requests, rsp_ready held high.
        for (int i = 0; i < 9; i++) begin
            core_val    = vecs[i].val;
            core_lat    = vecs[i].lat;
            core_silent = vecs[i].silent;
            send(vecs[i].arg, vecs[i].exp_data, vecs[i].exp_mis, vecs[i].exp_to);
            drain();
        end
        core_silent = 1'b0;
        chk_counters("table");

        // Back-to-back requests 0 then 15.
        core_val = 46'd1;
        core_lat = 2;
        send(4'd0, 46'd1, 1'b0, 1'b0);
        core_val = 46'd1307674368000;
        send(4'd15, 46'd1307674368000, 1'b0, 1'b0);
        drain();
        chk_counters("b2b");

        // Busy core blocks acceptance; an unsolicited result is spurious.
        fact_out_busy = 1'b1;
        req_data      = 4'd2;
        req_valid     = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("busy_req_ready", 64'(req_ready), 64'd0);
            chk("busy_fact_in_valid", 64'(fact_in_valid), 64'd0);
        end
        @(negedge clk);
        fact_out_data  = 46'd99;
        fact_out_valid = 1'b1;
        @(negedge clk);
        fact_out_valid = 1'b0;
        exp_spur = sat_inc(exp_spur);
        #1;
        chk("spurious_idle", 64'(spurious_cnt), 64'(exp_spur));
        fact_out_busy = 1'b0;
        core_val = 46'd2;
        core_lat = 2;
        send(4'd2, 46'd2, 1'b0, 1'b0);
        drain();
        chk_counters("busy");

        // Downstream stall: response held stable for 10 cycles.
        rsp_ready = 1'b0;
        core_val  = 46'd720;
        core_lat  = 3;
        send(4'd6, 46'd720, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("hold_rsp_arrived", 64'(rsp_valid), 64'd1);
        repeat (10) begin
            @(negedge clk);
            #1;
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rsp_arg", 64'(rsp_arg), 64'd6);
            chk("hold_rsp_data", 64'(rsp_data), 64'd720);
            chk("hold_done_cnt", 64'(done_cnt), 64'(exp_done));
        end
        rsp_ready = 1'b1;
        drain();
        chk_counters("hold");

        // Reset for one cycle during WAIT; the late result is spurious.
        core_val = 46'd40320;
        core_lat = 10;
        send(4'd8, 46'd40320, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sb.delete();
        exp_done = '0;
        exp_mis  = '0;
        exp_to   = '0;
        exp_spur = '0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_fact_in_valid", 64'(fact_in_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk_counters("midrst");
        repeat (10) @(negedge clk);
        exp_spur = sat_inc(exp_spur);
        #1;
        chk("midrst_late_spurious", 64'(spurious_cnt), 64'(exp_spur));

        // Normal operation after reset.
        core_val = 46'd120;
        core_lat = 6;
        send(4'd5, 46'd120, 1'b0, 1'b0);
        drain();
        chk_counters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
